// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the RV32 ALU and the units that share it.
//   Holds the ALU function-code constants, the arbiter state encoding and
//   default widths.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int FUNC_W_DEF = 4;

    // ALU function codes. Codes 11..15 are unused; the ALU returns 0 for them.
    localparam logic [3:0] FUNC_ADD      = 4'd0;
    localparam logic [3:0] FUNC_SUB      = 4'd1;
    localparam logic [3:0] FUNC_SLL      = 4'd2;
    localparam logic [3:0] FUNC_SLT      = 4'd3;
    localparam logic [3:0] FUNC_SLTU     = 4'd4;
    localparam logic [3:0] FUNC_XOR      = 4'd5;
    localparam logic [3:0] FUNC_SRL      = 4'd6;
    localparam logic [3:0] FUNC_SRA      = 4'd7;
    localparam logic [3:0] FUNC_OR       = 4'd8;
    localparam logic [3:0] FUNC_AND      = 4'd9;
    localparam logic [3:0] FUNC_ADD_JALR = 4'd10;

    // Arbiter sequencing:
    //   IDLE - no operation in flight, requests may be accepted
    //   EXEC - ALU evaluating the registered operands
    //   RESP - result held on the owner's response channel
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way combinational grant selector for a shared unit.
//
//   Ports:
//     i_valid0     - requester 0 has a request
//     i_valid1     - requester 1 has a request
//     i_last_grant - port that won the previous grant
//     o_pick       - selected port (0 or 1); meaningful when o_any is high
//     o_any        - at least one requester is valid
//
//   PRIO_FIX = 0 : round-robin, the port that did not win last time wins a tie.
//   PRIO_FIX = 1 : port 0 always wins a tie.
// -----------------------------------------------------------------------------
module rr_arb2 #(
    parameter bit PRIO_FIX = 1'b0
) (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_pick,
    output logic o_any
);

    logic w_tie_pick;

    // Tie-break winner: fixed priority always picks 0, round-robin picks the
    // port that lost the previous grant.
    assign w_tie_pick = PRIO_FIX ? 1'b0 : ~i_last_grant;

    always_comb begin
        o_pick = 1'b0;
        if (i_valid0 && i_valid1) begin
            o_pick = w_tie_pick;
        end else if (i_valid1) begin
            o_pick = 1'b1;
        end
        o_any = i_valid0 | i_valid1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational RV32 ALU between two requesters:
//   port 0 = execute stage, port 1 = address-generation / branch unit.
//
//   Ports:
//     clk, rst_n                 - clock (rising edge), async active-low reset
//     req{0,1}_valid/_ready      - request handshake
//     req{0,1}_func/_a/_b        - request function code and operands
//     rsp{0,1}_valid/_ready      - response handshake
//     rsp{0,1}_result/_eq/_lt/_ltu - response payload (shared buses, only
//                                  meaningful while that port's valid is high)
//     alu_func/alu_a/alu_b       - registered ALU inputs (sole driver)
//     alu_result/alu_eq/alu_a_lt_b/alu_a_lt_ub - ALU outputs
//     dbg_state                  - current sequencing state
//
//   Handshake semantics (both channels): a transfer happens on a rising edge
//   where valid and ready are both high. A producer holds valid and payload
//   stable until the transfer. Here req*_ready depends combinationally on
//   req*_valid and on rsp*_ready, so requesters must not derive valid from
//   ready.
//
//   Timing: accept at edge N -> ALU evaluates during EXEC -> result captured
//   at edge N+1 -> rsp valid from the cycle after N+1 until consumed. A new
//   request can be accepted in the same cycle the response is consumed, giving
//   one operation every two cycles under sustained load.
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int FUNC_W   = FUNC_W_DEF,
    parameter int PRIO_FIX = 0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [FUNC_W-1:0] req0_func,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [FUNC_W-1:0] req1_func,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_eq,
    output logic              rsp0_lt,
    output logic              rsp0_ltu,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_eq,
    output logic              rsp1_lt,
    output logic              rsp1_ltu,

    output logic [FUNC_W-1:0] alu_func,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_eq,
    input  logic              alu_a_lt_b,
    input  logic              alu_a_lt_ub,

    output arb_state_t        dbg_state
);

    // -------------------------------------------------------------------------
    // State and registers
    // -------------------------------------------------------------------------
    arb_state_t        r_state;
    arb_state_t        w_next_state;

    logic              r_owner;       // port the in-flight op belongs to
    logic              r_last_grant;  // port that won the last grant

    logic [FUNC_W-1:0] r_alu_func;
    logic [WIDTH-1:0]  r_alu_a;
    logic [WIDTH-1:0]  r_alu_b;

    logic [WIDTH-1:0]  r_result;
    logic              r_eq;
    logic              r_lt;
    logic              r_ltu;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic              w_pick;
    logic              w_any_valid;
    logic              w_rsp_ready_sel;
    logic              w_rsp_hs;
    logic              w_accept_en;
    logic              w_accept;

    logic [FUNC_W-1:0] w_sel_func;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
    rr_arb2 #(
        .PRIO_FIX (PRIO_FIX != 0)
    ) u_rr_arb2 (
        .i_valid0     (req0_valid),
        .i_valid1     (req1_valid),
        .i_last_grant (r_last_grant),
        .o_pick       (w_pick),
        .o_any        (w_any_valid)
    );

    // -------------------------------------------------------------------------
    // Accept window and request readies
    // -------------------------------------------------------------------------
    always_comb begin
        w_rsp_ready_sel = r_owner ? rsp1_ready : rsp0_ready;
        // In RESP the owner's valid is always high, so the handshake reduces
        // to the owner's ready.
        w_rsp_hs        = (r_state == RESP) && w_rsp_ready_sel;
        // Gated with rst_n so no transfer can be signalled while the block is
        // held in reset (state is forced to IDLE asynchronously).
        w_accept_en     = rst_n && ((r_state == IDLE) || w_rsp_hs);
        w_accept        = w_accept_en && w_any_valid;
        req0_ready      = w_accept_en && req0_valid && !w_pick;
        req1_ready      = w_accept_en && req1_valid &&  w_pick;
    end

    // Operand mux towards the ALU input registers.
    always_comb begin
        w_sel_func = req0_func;
        w_sel_a    = req0_a;
        w_sel_b    = req0_b;
        if (w_pick) begin
            w_sel_func = req1_func;
            w_sel_a    = req1_a;
            w_sel_b    = req1_b;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                if (w_rsp_hs) begin
                    w_next_state = w_accept ? EXEC : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // ALU input registers and grant bookkeeping (loaded on accept)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_func   <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_owner      <= 1'b0;
            // Port 0 wins the first tie after reset.
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_alu_func   <= w_sel_func;
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_owner      <= w_pick;
            r_last_grant <= w_pick;
        end
    end

    // -------------------------------------------------------------------------
    // Result capture: the ALU output is valid at the end of the EXEC cycle.
    // The registers then hold until the next EXEC, keeping the response stable
    // under backpressure.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
            r_ltu    <= 1'b0;
        end else if (r_state == EXEC) begin
            r_result <= alu_result;
            r_eq     <= alu_eq;
            r_lt     <= alu_a_lt_b;
            r_ltu    <= alu_a_lt_ub;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign alu_func    = r_alu_func;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;

    assign rsp0_valid  = (r_state == RESP) && !r_owner;
    assign rsp1_valid  = (r_state == RESP) &&  r_owner;

    // Payload buses are shared; only the port with valid high looks at them.
    assign rsp0_result = r_result;
    assign rsp0_eq     = r_eq;
    assign rsp0_lt     = r_lt;
    assign rsp0_ltu    = r_ltu;

    assign rsp1_result = r_result;
    assign rsp1_eq     = r_eq;
    assign rsp1_lt     = r_lt;
    assign rsp1_ltu    = r_ltu;

    assign dbg_state   = r_state;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational RV32 ALU between two requesters: port 0 is the execute stage and port 1 is the address-generation/branch unit. The block arbitrates with valid/ready handshakes and registers the chosen operands onto the ALU inputs. It captures the result and compare flags one cycle later and holds them on the winning port's response channel until that channel accepts them. It sits between the requesters and the ALU instance, and is the only driver of the ALU inputs.

Parameters:
WIDTH, 32, operand/result width
FUNC_W, 4, ALU function-code width
PRIO_FIX, 0, 0 = round-robin, 1 = fixed priority with port 0 always winning

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid / req1_valid  in  1  request present
req0_ready / req1_ready  out  1  request accepted this cycle
req0_func / req1_func  in  FUNC_W  ALU function code
req0_a / req1_a  in  WIDTH  operand A
req0_b / req1_b  in  WIDTH  operand B
rsp0_valid / rsp1_valid  out  1  response present
rsp0_ready / rsp1_ready  in  1  response consumed
rsp0_result / rsp1_result  out  WIDTH  ALU result
rsp0_eq / rsp1_eq  out  1  A == B
rsp0_lt / rsp1_lt  out  1  signed A < B
rsp0_ltu / rsp1_ltu  out  1  unsigned A < B
alu_func  out  FUNC_W  registered function code to the ALU
alu_a  out  WIDTH  registered operand A to the ALU
alu_b  out  WIDTH  registered operand B to the ALU
alu_result  in  WIDTH  ALU output
alu_eq  in  1  ALU equality flag
alu_a_lt_b  in  1  ALU signed less-than flag
alu_a_lt_ub  in  1  ALU unsigned less-than flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- States: IDLE, EXEC, RESP.
- Reset values:
  - state = IDLE.
  - alu_func/alu_a/alu_b = 0.
  - Result and flag registers = 0.
  - rsp*_valid = 0.
  - owner = 0.
  - last_grant = 1, so port 0 wins the first tie.
- Grant, combinational:
  - pick = the only valid port, if just one is valid.
  - If both are valid: PRIO_FIX=1 picks port 0; otherwise pick = ~last_grant.
- Accept window (accept_en):
  - accept_en = (state==IDLE) OR (state==RESP AND rsp[owner]_valid AND rsp[owner]_ready).
  - req[pick]_ready = accept_en AND req[pick]_valid. The other port's ready = 0.
  - There is a combinational path rsp_ready -> req_ready. Requesters must not make valid depend on ready.
- On accept (valid & ready at edge N):
  - Latch func/a/b into alu_func/alu_a/alu_b.
  - owner <= pick; last_grant <= pick.
  - state <= EXEC.
- EXEC (one cycle):
  - The ALU evaluates from the registered inputs.
  - At edge N+1, capture alu_result/alu_eq/alu_a_lt_b/alu_a_lt_ub into the result registers.
  - state <= RESP.
- Response latency: rsp[owner]_valid = 1 from the cycle after edge N+1. One-cycle accept-to-valid latency.
- RESP:
  - rsp[owner]_valid held high. result and flags are stable until the handshake.
  - rsp[other]_valid = 0. The result/flag buses are shared by both ports and are meaningful only while that port's valid is high.
  - On handshake with a new accept in the same cycle: state <= EXEC (back-to-back, sustained throughput of 1 op per 2 cycles).
  - On handshake with no accept: state <= IDLE.
  - Without the handshake, stay in RESP. Backpressure is unbounded.
- While in EXEC, or in RESP without a handshake, both req*_ready = 0. Requests wait; there is no queueing.
- Function codes 4'b1011..4'b1111 pass through unmodified. The ALU returns 0 and the arbiter forwards that 0; it raises no error.
- Flags are returned for every op regardless of func, so branch compare uses any func.
- Reset mid-operation (EXEC or RESP): the in-flight op is dropped silently and no response is issued. All outputs return to their reset values asynchronously.
- req*_valid dropping without acceptance: legal; no state change.

Decomposition:
- Shared package alu_pkg:
  - ALU function-code constants: FUNC_ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, ADD_JALR=10.
  - arb_state_t enum {IDLE, EXEC, RESP}.
  - WIDTH/FUNC_W defaults.
- One natural sub-module, rr_arb2: a 2-way grant with PRIO_FIX and last_grant inputs, producing a pick output. It is reusable for other shared units.

Test Plan:
1. req0 ADD A=5 B=7 alone, rsp0_ready=1 -> req0_ready high at accept edge N; rsp0_valid high one cycle later with result=12, eq=0, lt=1, ltu=1; rsp1_valid stays 0.
2. After reset, both valid every cycle (req0 SUB 10,3; req1 XOR 0xF0,0x0F) -> grants alternate 0,1,0,1; responses 7 then 0xFF; with PRIO_FIX=1 port 0 wins every grant and port 1 starves.
3. req1 SLT A=0xFFFFFFFF B=1 with rsp1_ready low for 5 cycles -> rsp1_valid held, result=1, lt=1, ltu=0 stable; req0_ready=0 throughout; service resumes the cycle rsp1_ready rises.
4. req0 valid during the RESP handshake of a port-1 op -> accepted in that same cycle; a new response every 2 cycles over a 4-op burst.
5. SRA A=0x80000000 B=0x24 -> 0xF8000000 (shamt=4); ADD_JALR 0x1001+0x2 -> 0x1002; func 4'b1111 -> result=0.
6. Assert rst_n low during EXEC, release 2 cycles later -> no rsp*_valid ever asserted for the dropped op; alu_a=0; the next request completes normally.
